// File: rtl/handshake_data_rx_if.sv
// Bundle for the receiver: the req/ack/data crossing from domain a
// plus the valid/ready word output toward the domain-b consumer.
// slave  : receiver side (req_in, data_in, out_ready in; ack_out, out_data, out_valid out)
// master : environment side (drives req_in, data_in, out_ready; observes the rest)
interface handshake_data_rx_if #(
   parameter int WIDTH = 8
);
   logic             req_in;
   logic [WIDTH-1:0] data_in;
   logic             ack_out;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  req_in,
      input  data_in,
      input  out_ready,
      output ack_out,
      output out_data,
      output out_valid
   );

   modport master (
      output req_in,
      output data_in,
      output out_ready,
      input  ack_out,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/handshake_data_rx.sv
// Domain-b receiver for a 4-phase req/ack bundled-data crossing.
// Ports: clk_b, rst_b (sync, active high); bus (slave modport:
//   req_in, data_in, out_ready in / ack_out, out_data, out_valid out);
//   busy, xfer_count, proto_err status outputs.
module handshake_data_rx #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 clk_b,
   input  logic                 rst_b,
   handshake_data_rx_if.slave   bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     xfer_count,
   output logic                 proto_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] VALID = 2'd1;
   localparam logic [1:0] ACK   = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;

   logic [1:0]       state_q, state_d;
   logic             ack_q, ack_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Only the synchronized request is ever looked at; data_in is
   // trusted stable while req is high and sampled on the capture edge.
   assign req_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_s) begin
               state_d = VALID;
               data_d  = bus.data_in;
               valid_d = 1'b1;
            end
         end
         VALID: begin
            // Delivery takes priority over a simultaneous req drop;
            // the drop is then seen in ACK as an ordinary release.
            if (bus.out_ready) begin
               state_d = ACK;
               valid_d = 1'b0;
               ack_d   = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end else if (!req_s) begin
               state_d = IDLE;
               valid_d = 1'b0;
               err_d   = 1'b1;
            end
         end
         ACK: begin
            if (!req_s) begin
               state_d = IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_b) begin
      if (rst_b) begin
         sync_q  <= '0;
         state_q <= IDLE;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
         state_q <= state_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign bus.ack_out   = ack_q;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign busy          = (state_q != IDLE);
   assign xfer_count    = cnt_q;
   assign proto_err     = err_q;

endmodule

// File: tb/tb_handshake_data_rx.sv
// Directed bench for handshake_data_rx (WIDTH=8, SYNC_STAGES=2, CNT_W=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_handshake_data_rx;

   logic       clk_b;
   logic       rst_b;
   logic       busy;
   logic [3:0] xfer_count;
   logic       proto_err;

   int total;
   int bad;
   logic [7:0] beats[$];

   handshake_data_rx_if #(.WIDTH(8)) bus ();

   handshake_data_rx #(
      .WIDTH(8),
      .SYNC_STAGES(2),
      .CNT_W(4)
   ) dut (
      .clk_b(clk_b),
      .rst_b(rst_b),
      .bus(bus.slave),
      .busy(busy),
      .xfer_count(xfer_count),
      .proto_err(proto_err)
   );

   initial clk_b = 1'b0;
   always #5 clk_b = ~clk_b;

   always @(posedge clk_b)
      if (!rst_b && bus.out_valid && bus.out_ready)
         beats.push_back(bus.out_data);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_b);
         #1;
      end
   endtask

   // One full 4-phase cycle with out_ready high; req held for
   // `hold` extra cycles after ack to show no re-capture.
   task automatic xfer(input logic [7:0] d, input int hold);
      int n;
      bus.req_in  = 1'b1;
      bus.data_in = d;
      n = 0;
      while (!bus.ack_out && n < 20) begin
         tick(1);
         n++;
      end
      chk("ack_rise", {31'd0, bus.ack_out}, 32'd1);
      for (int i = 0; i < hold; i++) begin
         tick(1);
         chk("hold_novalid", {31'd0, bus.out_valid}, 32'd0);
         chk("hold_ack", {31'd0, bus.ack_out}, 32'd1);
      end
      bus.req_in = 1'b0;
      n = 0;
      while (bus.ack_out && n < 20) begin
         tick(1);
         n++;
      end
      chk("ack_fall", {31'd0, bus.ack_out}, 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.req_in    = 1'b0;
      bus.data_in   = 8'h00;
      bus.out_ready = 1'b0;
      rst_b = 1'b1;
      tick(2);
      rst_b = 1'b0;

      chk("rst_ack", {31'd0, bus.ack_out}, 32'd0);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_data", {24'd0, bus.out_data}, 32'd0);
      chk("rst_cnt", {28'd0, xfer_count}, 32'd0);
      chk("rst_err", {31'd0, proto_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // basic transfer
      bus.out_ready = 1'b1;
      bus.req_in    = 1'b1;
      bus.data_in   = 8'hA5;
      tick(2);
      chk("b_valid_e2", {31'd0, bus.out_valid}, 32'd0);
      tick(1);
      chk("b_valid_e3", {31'd0, bus.out_valid}, 32'd1);
      chk("b_data_e3", {24'd0, bus.out_data}, 32'hA5);
      chk("b_busy_e3", {31'd0, busy}, 32'd1);
      tick(1);
      chk("b_ack_e4", {31'd0, bus.ack_out}, 32'd1);
      chk("b_valid_e4", {31'd0, bus.out_valid}, 32'd0);
      chk("b_cnt_e4", {28'd0, xfer_count}, 32'd1);
      bus.req_in = 1'b0;
      tick(2);
      chk("b_ack_e6", {31'd0, bus.ack_out}, 32'd1);
      tick(1);
      chk("b_ack_e7", {31'd0, bus.ack_out}, 32'd0);
      chk("b_busy_e7", {31'd0, busy}, 32'd0);

      // backpressure
      bus.out_ready = 1'b0;
      bus.req_in    = 1'b1;
      bus.data_in   = 8'h3C;
      tick(3);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("bp_hold_v", {31'd0, bus.out_valid}, 32'd1);
         chk("bp_hold_d", {24'd0, bus.out_data}, 32'h3C);
         chk("bp_hold_a", {31'd0, bus.ack_out}, 32'd0);
      end
      bus.out_ready = 1'b1;
      tick(1);
      chk("bp_ack", {31'd0, bus.ack_out}, 32'd1);
      chk("bp_cnt", {28'd0, xfer_count}, 32'd2);
      bus.req_in = 1'b0;
      tick(3);
      chk("bp_ack_fall", {31'd0, bus.ack_out}, 32'd0);
      chk("bp_cnt2", {28'd0, xfer_count}, 32'd2);

      // protocol violation: req drops while word is unconsumed
      bus.out_ready = 1'b0;
      bus.req_in    = 1'b1;
      bus.data_in   = 8'h77;
      tick(3);
      chk("pv_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.req_in = 1'b0;
      tick(2);
      chk("pv_valid_e2", {31'd0, bus.out_valid}, 32'd1);
      chk("pv_err_e2", {31'd0, proto_err}, 32'd0);
      tick(1);
      chk("pv_err", {31'd0, proto_err}, 32'd1);
      chk("pv_valid_e3", {31'd0, bus.out_valid}, 32'd0);
      chk("pv_cnt", {28'd0, xfer_count}, 32'd2);
      chk("pv_busy", {31'd0, busy}, 32'd0);
      bus.out_ready = 1'b1;
      bus.req_in    = 1'b1;
      bus.data_in   = 8'h11;
      tick(3);
      chk("pv2_data", {24'd0, bus.out_data}, 32'h11);
      tick(1);
      chk("pv2_cnt", {28'd0, xfer_count}, 32'd3);
      chk("pv2_err", {31'd0, proto_err}, 32'd1);
      bus.req_in = 1'b0;
      tick(3);

      // back-to-back with req held in ACK
      beats.delete();
      for (int k = 1; k <= 4; k++)
         xfer(8'(k), 4);
      chk("bb_beats", beats.size(), 32'd4);
      for (int k = 0; k < 4 && k < beats.size(); k++)
         chk("bb_order", {24'd0, beats[k]}, k + 1);
      chk("bb_cnt", {28'd0, xfer_count}, 32'd7);

      // counter wrap from a clean reset
      rst_b = 1'b1;
      tick(1);
      rst_b = 1'b0;
      chk("w_err_clr", {31'd0, proto_err}, 32'd0);
      for (int k = 1; k <= 17; k++) begin
         xfer(8'(k + 8'h40), 0);
         chk("w_cnt", {28'd0, xfer_count}, k % 16);
      end

      // reset while in ACK with req still high
      bus.req_in  = 1'b1;
      bus.data_in = 8'h5A;
      tick(4);
      chk("r_ack_pre", {31'd0, bus.ack_out}, 32'd1);
      rst_b = 1'b1;
      tick(1);
      chk("r_ack", {31'd0, bus.ack_out}, 32'd0);
      chk("r_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("r_cnt", {28'd0, xfer_count}, 32'd0);
      chk("r_busy", {31'd0, busy}, 32'd0);
      rst_b = 1'b0;
      bus.out_ready = 1'b0;
      tick(2);
      chk("r_valid_e2", {31'd0, bus.out_valid}, 32'd0);
      tick(1);
      chk("r_valid_e3", {31'd0, bus.out_valid}, 32'd1);
      chk("r_data_e3", {24'd0, bus.out_data}, 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
